// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner with one shared debounce timer and a valid/ready key output.
// Optional auto-repeat of a held key when KEY_REPEAT_EN is defined.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_CNT_MAX   = 50_000,
  parameter int unsigned DEB_CNT_MAX    = 2_500_000,
  parameter int unsigned REPEAT_CNT_MAX = 62_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_overrun
);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_EMIT     = 2'd2;
  localparam logic [1:0] S_WAIT_REL = 2'd3;

  localparam logic [31:0] SCAN_LAST = 32'(SCAN_CNT_MAX - 1);
  localparam logic [31:0] DEB_LAST  = 32'(DEB_CNT_MAX - 1);

  if (SCAN_CNT_MAX == 0 || DEB_CNT_MAX == 0 || REPEAT_CNT_MAX == 0) begin : g_bad_params
    $error("keypad_scan_ctrl: counter limits must be non-zero");
  end

  logic [3:0]  rows_meta_q, rows_s_q;
  logic [1:0]  state_q, state_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [3:0]  pat_q, pat_d;
  logic [31:0] scan_cnt_q, scan_cnt_d;
  logic [31:0] deb_cnt_q, deb_cnt_d;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_overrun_q, key_overrun_d;
  logic        issue;
  logic        one_low;
  logic [1:0]  low_idx;

`ifdef KEY_REPEAT_EN
  localparam logic [31:0] REP_LAST = 32'(REPEAT_CNT_MAX - 1);
  logic [31:0] rep_cnt_q, rep_cnt_d;
`endif

  assign col_out     = ~(4'b0001 << col_idx_q);
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_overrun = key_overrun_q;

  always_comb begin
    one_low = 1'b0;
    low_idx = '0;
    case (rows_s_q)
      4'b1110: begin one_low = 1'b1; low_idx = 2'd0; end
      4'b1101: begin one_low = 1'b1; low_idx = 2'd1; end
      4'b1011: begin one_low = 1'b1; low_idx = 2'd2; end
      4'b0111: begin one_low = 1'b1; low_idx = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    row_idx_d  = row_idx_q;
    pat_d      = pat_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    issue      = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_cnt_d  = '0;
`endif
    case (state_q)
      S_SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (one_low) begin
            pat_d     = rows_s_q;
            row_idx_d = low_idx;
            deb_cnt_d = '0;
            state_d   = S_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 32'd1;
        end
      end
      // The key is written on the edge that enters EMIT, so key_valid rises
      // one cycle after the final debounce match.
      S_DEBOUNCE: begin
        if (rows_s_q == pat_q) begin
          if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_d = '0;
            state_d   = S_EMIT;
            issue     = 1'b1;
          end else begin
            deb_cnt_d = deb_cnt_q + 32'd1;
          end
        end else begin
          deb_cnt_d = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = S_SCAN;
        end
      end
      S_EMIT: begin
        deb_cnt_d = '0;
        state_d   = S_WAIT_REL;
      end
      default: begin
        if (rows_s_q == 4'b1111) begin
          if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_d = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = S_SCAN;
          end else begin
            deb_cnt_d = deb_cnt_q + 32'd1;
          end
        end else begin
          deb_cnt_d = '0;
        end
`ifdef KEY_REPEAT_EN
        if (rows_s_q == pat_q) begin
          if (rep_cnt_q == REP_LAST) begin
            issue = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 32'd1;
          end
        end
`endif
      end
    endcase
  end

  always_comb begin
    key_valid_d   = key_valid_q;
    key_code_d    = key_code_q;
    key_overrun_d = 1'b0;
    if (issue) begin
      if (!key_valid_q || key_ready) begin
        key_valid_d = 1'b1;
        key_code_d  = {row_idx_q, col_idx_q};
      end else begin
        key_overrun_d = 1'b1;
      end
    end else if (key_valid_q && key_ready) begin
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows_meta_q   <= '1;
      rows_s_q      <= '1;
      state_q       <= S_SCAN;
      col_idx_q     <= '0;
      row_idx_q     <= '0;
      pat_q         <= '1;
      scan_cnt_q    <= '0;
      deb_cnt_q     <= '0;
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      key_overrun_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_q     <= '0;
`endif
    end else begin
      rows_meta_q   <= row_in;
      rows_s_q      <= rows_meta_q;
      state_q       <= state_d;
      col_idx_q     <= col_idx_d;
      row_idx_q     <= row_idx_d;
      pat_q         <= pat_d;
      scan_cnt_q    <= scan_cnt_d;
      deb_cnt_q     <= deb_cnt_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_overrun_q <= key_overrun_d;
`ifdef KEY_REPEAT_EN
      rep_cnt_q     <= rep_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a keypad matrix model drives row_in from col_out,
// expected key codes are queued at press time and popped on each valid/ready handshake.
module tb_keypad_scan_ctrl;

  localparam int unsigned SCAN = 4;
  localparam int unsigned DEB  = 16;
  localparam int unsigned REP  = 64;
`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_ISSUES = 4;
`else
  localparam int unsigned REP_ISSUES = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_ready = 1'b0;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_overrun;
  logic [15:0] keys = '0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned hs_cnt   = 0;
  int unsigned ovr_cnt  = 0;
  logic [3:0]  exp_q[$];

  keypad_scan_ctrl #(
    .SCAN_CNT_MAX  (SCAN),
    .DEB_CNT_MAX   (DEB),
    .REPEAT_CNT_MAX(REP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_ready  (key_ready),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_overrun(key_overrun)
  );

  always #5 clk = ~clk;

  // Key index = row*4 + col; a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (key_overrun) ovr_cnt++;
      if (key_valid && key_ready) begin
        hs_cnt++;
        chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("key_code", 32'(key_code), 32'(exp_q.pop_front()));
      end
    end
  end

  // kind 0: col_out == c, 1: key_valid high, 2: hs_cnt > n, 3: ovr_cnt > n
  task automatic wait_for(input int kind, input logic [3:0] c, input int unsigned n,
                          input int unsigned budget, input string tag);
    bit ok = 1'b0;
    for (int unsigned i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      case (kind)
        0:       ok = (col_out == c);
        1:       ok = (key_valid == 1'b1);
        2:       ok = (hs_cnt > n);
        default: ok = (ovr_cnt > n);
      endcase
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned hs0;
    logic [3:0]  ecol;

    // Reset state
    step(3);
    chk("rst_col", 32'(col_out), 32'(4'b1110));
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_ovr", 32'(key_overrun), 32'd0);
    rst = 1'b1;

    // Idle scan: each column held for SCAN cycles
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      ecol = ~(4'b0001 << ((j / 4) % 4));
      chk("scan_col", 32'(col_out), 32'(ecol));
    end
    chk("idle_valid", 32'(key_valid), 32'd0);

    // Clean press of key 9 (row 2, col 1)
    key_ready = 1'b1;
    step(1);
    hs0 = hs_cnt;
    keys = 16'h0001 << 9;
    exp_q.push_back(4'd9);
    wait_for(2, 4'h0, hs0, 100, "press_hs");
    chk("press_col_held", 32'(col_out), 32'(4'b1101));
    step(10);
    keys = '0;
    wait_for(0, 4'b1011, 0, 60, "press_resume");
    chk("press_issues", hs_cnt - hs0, 32'd1);

    // Bounce: row 2 low on col 1 for 6 cycles only
    wait_for(0, 4'b1101, 0, 40, "bounce_col1");
    hs0 = hs_cnt;
    keys = 16'h0001 << 9;
    repeat (6) @(negedge clk);
    chk("bounce_hold", 32'(col_out), 32'(4'b1101));
    keys = '0;
    wait_for(0, 4'b1011, 0, 12, "bounce_advance");
    chk("bounce_issues", hs_cnt - hs0, 32'd0);
    chk("bounce_valid", 32'(key_valid), 32'd0);

    // Overrun: key 0 pending with ready low, then key 5 is dropped
    step(1);
    key_ready = 1'b0;
    keys = 16'h0001;
    exp_q.push_back(4'd0);
    wait_for(1, 4'h0, 0, 100, "ovr_first_valid");
    step(1);
    keys = '0;
    wait_for(0, 4'b1101, 0, 60, "ovr_release0");
    step(1);
    keys = 16'h0001 << 5;
    wait_for(3, 4'h0, 0, 150, "ovr_seen");
    step(1);
    keys = '0;
    wait_for(0, 4'b1011, 0, 60, "ovr_release5");
    chk("ovr_pulses", ovr_cnt, 32'd1);
    chk("ovr_code_kept", 32'(key_code), 32'd0);
    chk("ovr_valid_kept", 32'(key_valid), 32'd1);
    step(1);
    key_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ovr_valid_clear", 32'(key_valid), 32'd0);

    // Ghost: rows 0 and 3 low on col 2
    step(1);
    hs0 = hs_cnt;
    keys = (16'h0001 << 2) | (16'h0001 << 14);
    wait_for(0, 4'b1011, 0, 40, "ghost_col2");
    wait_for(0, 4'b0111, 0, 10, "ghost_col3");
    wait_for(0, 4'b1011, 0, 20, "ghost_col2_again");
    wait_for(0, 4'b0111, 0, 10, "ghost_col3_again");
    chk("ghost_issues", hs_cnt - hs0, 32'd0);
    chk("ghost_valid", 32'(key_valid), 32'd0);
    step(1);
    keys = '0;
    step(20);

    // Held key 7 (row 1, col 3): auto-repeat only when enabled
    hs0 = hs_cnt;
    keys = 16'h0001 << 7;
    for (int unsigned i = 0; i < REP_ISSUES; i++) exp_q.push_back(4'd7);
    wait_for(2, 4'h0, hs0, 100, "rep_first_hs");
    step(200);
    keys = '0;
    wait_for(0, 4'b1110, 0, 60, "rep_resume");
    step(5);
    chk("rep_issues", hs_cnt - hs0, 32'(REP_ISSUES));

    // Asynchronous reset drops a pending key
    key_ready = 1'b0;
    keys = 16'h0001 << 3;
    wait_for(1, 4'h0, 0, 100, "rst_mid_valid");
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(key_valid), 32'd0);
    chk("rst_mid_col", 32'(col_out), 32'(4'b1110));
    chk("rst_mid_code", 32'(key_code), 32'd0);
    keys = '0;
    step(2);
    rst = 1'b1;
    step(5);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Scans the detonator's 4x4 active-low matrix keypad, one column at a time.
- Shares a single debounce timer across all 16 keys: the timer is applied only to the candidate key found by the scan.
- Each confirmed press is delivered to the code-entry FSM as a 4-bit key code over a valid/ready handshake.
- Replaces per-button debounce instances on the keypad path.

Parameters:
- SCAN_CNT_MAX, 50_000: cycles each column is driven before its rows are sampled (settle time).
- DEB_CNT_MAX, 2_500_000: cycles of stable level required to confirm a press or a release (20 ms at 125 MHz).
- REPEAT_CNT_MAX, 62_500_000: auto-repeat period in cycles; used only when KEY_REPEAT_EN is defined.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- col_out  output  4  column drive, active-low, exactly one bit low at any time.
- key_ready  input  1  consumer accepts key_code.
- key_valid  output  1  key_code holds an unconsumed key.
- key_code  output  4  {row_idx[1:0], col_idx[1:0]}.
- key_overrun  output  1  one-cycle pulse when a confirmed key is dropped.

Behaviour:
- Reset values (rst low, asynchronous):
  - state = SCAN; col_idx = 0; col_out = 4'b1110.
  - scan_cnt = 0; deb_cnt = 0; rep_cnt = 0.
  - key_valid = 0; key_code = 0; key_overrun = 0.
  - 2-FF row synchronizer = 4'b1111.
- Synchronization: row_in passes through a 2-FF synchronizer (rows_s); all decisions use rows_s only.
- col_out is always ~(4'b0001 << col_idx).
- SCAN:
  - scan_cnt increments every cycle.
  - At scan_cnt == SCAN_CNT_MAX-1: scan_cnt <= 0, then rows_s is evaluated.
    - Exactly one bit low: capture pattern and row_idx, deb_cnt <= 0, go to DEBOUNCE. col_idx is held.
    - All high, or more than one bit low (ghost/multi-key): col_idx <= col_idx+1, wrapping 3 -> 0.
- DEBOUNCE:
  - rows_s == captured pattern: deb_cnt increments.
  - Any mismatch: deb_cnt <= 0, col_idx advances, go to SCAN.
  - At deb_cnt == DEB_CNT_MAX-1 with a match: go to EMIT.
- EMIT (one cycle):
  - Issues the key {row_idx, col_idx} to the output register.
  - deb_cnt <= 0, go to WAIT_RELEASE.
- WAIT_RELEASE:
  - Column stays held.
  - rows_s all high: deb_cnt increments. Any row low: deb_cnt <= 0.
  - At deb_cnt == DEB_CNT_MAX-1 with all rows high: col_idx advances, go to SCAN.
- Output register and handshake:
  - key_valid & key_ready in a cycle: key_valid = 0 in the next cycle, unless an issue happens in that same cycle.
  - Issue while key_valid = 0, or while key_valid & key_ready in the same cycle: next cycle key_valid = 1 and key_code = new code.
  - Issue while key_valid = 1 and key_ready = 0: new key dropped. key_code and key_valid unchanged; key_overrun = 1 for exactly one cycle.
  - key_code is stable whenever key_valid = 1.
- Latency: a clean press is visible on key_valid 1 cycle after the deb_cnt == DEB_CNT_MAX-1 match cycle (EMIT registers the output).
- Counters: 32-bit, never overflow; each clears on state exit.
- Reset mid-operation: immediate return to the reset values. A pending key_valid is lost.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In WAIT_RELEASE, while rows_s == captured pattern, rep_cnt counts.
  - At rep_cnt == REPEAT_CNT_MAX-1: rep_cnt <= 0 and the same code is issued again, with the same handshake and overrun rules.
  - Any release or mismatch clears rep_cnt.
- Undefined: rep_cnt logic is absent. Exactly one issue per press.

Test Plan (SCAN_CNT_MAX=4, DEB_CNT_MAX=16, REPEAT_CNT_MAX=64):
1. Reset, rows idle 4'b1111 -> col_out cycles 1110, 1101, 1011, 0111, 1110, each for 4 cycles; key_valid stays 0.
2. Hold row 2 low only while col 1 is driven, for 40 cycles; key_ready = 1 -> one key_valid pulse, key_code = 4'b1001; scan resumes after 16 cycles of release.
3. Row 2 low for 6 cycles, then high (bounce) -> no key_valid; col_idx advances from 1 to 2.
4. Press key 0 with key_ready = 0, release, then press key 5 -> key_code stays 4'b0000, key_overrun pulses once. Raising key_ready clears key_valid the next cycle.
5. Rows 0 and 3 both low on col 2 -> no capture; scan continues to col 3.
6. With KEY_REPEAT_EN defined and key_ready = 1, hold key 7 for 200 cycles after confirm -> key_code 4'b0111 issued once at confirm, then every 64 cycles (4 total issues). Without the macro -> 1 issue.
